// File: rtl/ip_encoder_if.sv
// ip_encoder_if: bundles the request, header-field, payload-source and
// datagram-output signals of ip_encoder.
//   master : request side (drives start, header fields, len_data, data_in)
//   slave  : encoder side (drives rd_en, data_out, wr_en, busy, ok, fin)
interface ip_encoder_if;
    logic        start;
    logic [7:0]  type_of_ser;
    logic [15:0] identification;
    logic [2:0]  flag;
    logic [12:0] frag_offset;
    logic [7:0]  time_to_live;
    logic [7:0]  protocol;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [15:0] len_data;
    logic [31:0] data_in;
    logic        rd_en;
    logic [31:0] data_out;
    logic        wr_en;
    logic        busy;
    logic        ok;
    logic        fin;

    modport master (
        output start, type_of_ser, identification, flag, frag_offset,
               time_to_live, protocol, src_ip, dest_ip, len_data, data_in,
        input  rd_en, data_out, wr_en, busy, ok, fin
    );

    modport slave (
        input  start, type_of_ser, identification, flag, frag_offset,
               time_to_live, protocol, src_ip, dest_ip, len_data, data_in,
        output rd_en, data_out, wr_en, busy, ok, fin
    );
endinterface

// File: rtl/ip_encoder.sv
// ip_encoder: builds one IPv4 datagram (version 4, IHL 5, no options) per
// accepted start: five header words followed by the payload streamed from a
// show-ahead source, then a one-cycle fin with ok.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   enc   : ip_encoder_if.slave (start, header fields, len_data, data_in in;
//           rd_en, data_out, wr_en, busy, ok, fin out)
// Build option: define CHECKSUM_EN to compute the header checksum in a 5-cycle
// CSUM state (first header word 6 cycles after start); without it the checksum
// field is 0 and the first header word follows start by one cycle.
module ip_encoder (
    input  logic        clk,
    input  logic        reset,
    ip_encoder_if.slave enc
);
    localparam int unsigned W_DATA = 32;
    localparam int unsigned W_LEN  = 16;
    localparam int unsigned W_CNT  = 15;
    localparam logic [W_LEN-1:0] MAX_LEN   = W_LEN'(65515);
    localparam logic [W_LEN-1:0] HDR_BYTES = W_LEN'(20);
    localparam logic [7:0]       VER_IHL   = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
`ifdef CHECKSUM_EN
        CSUM,
`endif
        HDR,
        PAY,
        DONE
    } state_t;

    state_t            state_q, state_next;
    logic [W_CNT-1:0]  cnt_q, cnt_next;
    logic              len_ok_q, len_ok_next;
    logic [W_DATA-1:0] hdr_q, hdr_next;
    logic              latch_c;

    logic [7:0]        tos_q;
    logic [15:0]       id_q;
    logic [2:0]        flag_q;
    logic [12:0]       frag_q;
    logic [7:0]        ttl_q;
    logic [7:0]        proto_q;
    logic [31:0]       src_q;
    logic [31:0]       dst_q;
    logic [W_LEN-1:0]  len_q;

    logic              rd_en_q, wr_en_q, busy_q, ok_q, fin_q;

    logic [W_LEN-1:0]  tot_len_c;
    logic [W_DATA-1:0] word0_c;
    logic [15:0]       csum_field_c;
    logic [W_CNT-1:0]  n_words_c;
    logic              last_c;
    logic [W_DATA-1:0] keep_c;
    logic [W_DATA-1:0] pay_word_c;

    // First header word: in IDLE it is built straight from the inputs so the
    // no-checksum build can emit it on the cycle after start.
    assign tot_len_c = ((state_q == IDLE) ? enc.len_data : len_q) + HDR_BYTES;
    assign word0_c   = {VER_IHL, ((state_q == IDLE) ? enc.type_of_ser : tos_q), tot_len_c};

`ifdef CHECKSUM_EN
    logic [15:0] acc_q, acc_next, hw_a, hw_b;

    // Ones'-complement add with the end-around carry folded back in.
    function automatic logic [15:0] oc_add(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        s = 17'(x) + 17'(y);
        return s[15:0] + 16'(s[16]);
    endfunction

    // Halfword pair summed on each CSUM cycle; checksum field counts as 0.
    always_comb begin
        hw_a = '0;
        hw_b = '0;
        case (cnt_q)
            W_CNT'(0): begin hw_a = {VER_IHL, tos_q};   hw_b = tot_len_c;       end
            W_CNT'(1): begin hw_a = id_q;               hw_b = {flag_q, frag_q}; end
            W_CNT'(2): begin hw_a = {ttl_q, proto_q};   hw_b = 16'h0000;        end
            W_CNT'(3): begin hw_a = src_q[31:16];       hw_b = src_q[15:0];     end
            W_CNT'(4): begin hw_a = dst_q[31:16];       hw_b = dst_q[15:0];     end
            default:   begin hw_a = '0;                 hw_b = '0;              end
        endcase
        acc_next = oc_add(oc_add(acc_q, hw_a), hw_b);
    end

    // Checksum accumulator, cleared for every accepted datagram.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (latch_c) begin
            acc_q <= '0;
        end else if (state_q == CSUM) begin
            acc_q <= acc_next;
        end
    end

    assign csum_field_c = ~acc_q;
`else
    assign csum_field_c = 16'h0000;
`endif

    // Payload word count and trailing-byte mask for the final word.
    assign n_words_c = W_CNT'((17'(len_q) + 17'd3) >> 2);
    assign last_c    = (cnt_q == n_words_c - W_CNT'(1));

    always_comb begin
        keep_c = '1;
        if (last_c) begin
            case (len_q[1:0])
                2'd1:    keep_c = 32'hFF00_0000;
                2'd2:    keep_c = 32'hFFFF_0000;
                2'd3:    keep_c = 32'hFFFF_FF00;
                default: keep_c = '1;
            endcase
        end
    end

    assign pay_word_c = enc.data_in & keep_c;

    // Next state, counter, and the header word to present next cycle.
    always_comb begin
        state_next  = state_q;
        cnt_next    = cnt_q;
        len_ok_next = len_ok_q;
        hdr_next    = '0;
        latch_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc.start) begin
                    cnt_next = '0;
                    if (enc.len_data > MAX_LEN) begin
                        len_ok_next = 1'b0;
                        state_next  = DONE;
                    end else begin
                        len_ok_next = 1'b1;
                        latch_c     = 1'b1;
`ifdef CHECKSUM_EN
                        state_next  = CSUM;
`else
                        state_next  = HDR;
                        hdr_next    = word0_c;
`endif
                    end
                end
            end
`ifdef CHECKSUM_EN
            CSUM: begin
                if (cnt_q == W_CNT'(4)) begin
                    cnt_next   = '0;
                    state_next = HDR;
                    hdr_next   = word0_c;
                end else begin
                    cnt_next = cnt_q + W_CNT'(1);
                end
            end
`endif
            HDR: begin
                if (cnt_q == W_CNT'(4)) begin
                    cnt_next   = '0;
                    state_next = (len_q == '0) ? DONE : PAY;
                end else begin
                    cnt_next = cnt_q + W_CNT'(1);
                    case (cnt_q)
                        W_CNT'(0): hdr_next = {id_q, flag_q, frag_q};
                        W_CNT'(1): hdr_next = {ttl_q, proto_q, csum_field_c};
                        W_CNT'(2): hdr_next = src_q;
                        default:   hdr_next = dst_q;
                    endcase
                end
            end
            PAY: begin
                if (last_c) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_q + W_CNT'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_ok_q <= 1'b0;
        end else begin
            state_q  <= state_next;
            cnt_q    <= cnt_next;
            len_ok_q <= len_ok_next;
        end
    end

    // Header fields captured on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            tos_q   <= '0;
            id_q    <= '0;
            flag_q  <= '0;
            frag_q  <= '0;
            ttl_q   <= '0;
            proto_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
        end else if (latch_c) begin
            tos_q   <= enc.type_of_ser;
            id_q    <= enc.identification;
            flag_q  <= enc.flag;
            frag_q  <= enc.frag_offset;
            ttl_q   <= enc.time_to_live;
            proto_q <= enc.protocol;
            src_q   <= enc.src_ip;
            dst_q   <= enc.dest_ip;
            len_q   <= enc.len_data;
        end
    end

    // Status and strobe outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_q   <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            hdr_q   <= hdr_next;
            rd_en_q <= (state_next == PAY);
            wr_en_q <= (state_next == HDR) || (state_next == PAY);
            busy_q  <= (state_next != IDLE);
            fin_q   <= (state_next == DONE);
            ok_q    <= (state_next == DONE) && len_ok_next;
        end
    end

    assign enc.rd_en = rd_en_q;
    assign enc.wr_en = wr_en_q;
    assign enc.busy  = busy_q;
    assign enc.fin   = fin_q;
    assign enc.ok    = ok_q;
    // Payload passes straight through because the source is show-ahead;
    // hdr_q is zero whenever no header word is being driven.
    assign enc.data_out = (state_q == PAY) ? pay_word_c : hdr_q;
endmodule
